// File: rtl/conv_tile_sched.sv
// Per-layer tile sequencer: configures the PE controller, launches one tile at a time and
// prefetches the next tile's IFM into the other ping-pong buffer while the current one computes.
module conv_tile_sched #(
  parameter int TILE_W    = 6,
  parameter int DRAIN_CYC = 4,
  parameter int PERF_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        cfg_ci,
  input  logic [1:0]        cfg_co,
  input  logic [TILE_W-1:0] cfg_tiles,
  output logic              start_conv,
  output logic              start_again,
  output logic [1:0]        pe_cfg_ci,
  output logic [1:0]        pe_cfg_co,
  input  logic              pe_tile_done,
  output logic              pe_buf_sel,
  output logic              ld_req,
  output logic [TILE_W-1:0] ld_tile,
  output logic              ld_buf,
  input  logic              ld_ack,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done,
  output logic [PERF_W-1:0] perf_cycles,
  output logic [2:0]        state_dbg
);

  localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CFG    = 3'd1,
    S_LOAD0  = 3'd2,
    S_RUN    = 3'd3,
    S_WAITLD = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [TILE_W-1:0] tiles_q;
  logic [DW-1:0]     drain_cnt;
  logic              prefetch_ok;
  logic              run_first, run_first_n;
  logic              has_next, ack_ok, swap, accept;

  // Handshake: ld_req is a level held with stable ld_tile/ld_buf until ld_ack is sampled with
  // ld_req high; it drops the following cycle. ld_ack seen while ld_req is low is ignored.
  assign has_next  = (tile_idx < tiles_q);
  assign ack_ok    = ld_ack && ld_req;
  assign accept    = (state == S_IDLE) && start && !abort;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_comb begin
    ld_req  = 1'b0;
    ld_tile = '0;
    ld_buf  = 1'b0;
    case (state)
      S_LOAD0: ld_req = 1'b1;
      S_RUN, S_WAITLD: begin
        // Prefetch waits one cycle after a tile launch so the launch pulse stands alone.
        if ((state == S_WAITLD) || (!run_first && has_next && !prefetch_ok)) begin
          ld_req  = 1'b1;
          ld_tile = tile_idx + TILE_W'(1);
          ld_buf  = ~pe_buf_sel;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n     = state;
    swap        = 1'b0;
    done        = 1'b0;
    start_conv  = 1'b0;
    start_again = 1'b0;
    case (state)
      S_IDLE:  if (start) state_n = S_CFG;
      S_CFG: begin
        start_conv = 1'b1;
        state_n    = S_LOAD0;
      end
      S_LOAD0: if (ack_ok) state_n = S_RUN;
      S_RUN: begin
        start_again = run_first;
        if (pe_tile_done) begin
          if (!has_next) begin
            state_n = S_DRAIN;
          end else if (prefetch_ok || ack_ok) begin
            swap = 1'b1;
          end else begin
            state_n = S_WAITLD;
          end
        end
      end
      S_WAITLD: begin
        if (ack_ok) begin
          swap    = 1'b1;
          state_n = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DW'(DRAIN_CYC)) begin
          done    = !abort;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (abort) begin
      state_n = S_IDLE;
      swap    = 1'b0;
    end
    run_first_n = (state_n == S_RUN) && ((state != S_RUN) || swap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      run_first   <= 1'b0;
      prefetch_ok <= 1'b0;
      tile_idx    <= '0;
      pe_buf_sel  <= 1'b0;
      tiles_q     <= '0;
      pe_cfg_ci   <= 2'b00;
      pe_cfg_co   <= 2'b00;
      drain_cnt   <= '0;
      perf_cycles <= '0;
    end else begin
      state     <= state_n;
      run_first <= run_first_n;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + DW'(1) : '0;
      if (accept) begin
        pe_cfg_ci   <= cfg_ci;
        pe_cfg_co   <= cfg_co;
        tiles_q     <= cfg_tiles;
        tile_idx    <= '0;
        pe_buf_sel  <= 1'b0;
        prefetch_ok <= 1'b0;
        perf_cycles <= '0;
      end else if (busy && (perf_cycles != {PERF_W{1'b1}})) begin
        perf_cycles <= perf_cycles + PERF_W'(1);
      end
      if (swap) begin
        tile_idx    <= tile_idx + TILE_W'(1);
        pe_buf_sel  <= ~pe_buf_sel;
        prefetch_ok <= 1'b0;
      end else if ((state == S_RUN) && ack_ok) begin
        prefetch_ok <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_tile_sched.sv
// Directed bench for conv_tile_sched: each scenario task drives a scripted layer and checks
// hand-computed expectations inline; a negedge monitor tallies pulses and load acceptances.
module tb_conv_tile_sched;

  localparam int TILE_W    = 6;
  localparam int DRAIN_CYC = 4;
  localparam int PERF_W    = 16;

  logic              clk, rst_n, start, abort;
  logic [1:0]        cfg_ci, cfg_co;
  logic [TILE_W-1:0] cfg_tiles;
  logic              start_conv, start_again;
  logic [1:0]        pe_cfg_ci, pe_cfg_co;
  logic              pe_tile_done, pe_buf_sel;
  logic              ld_req, ld_buf, ld_ack;
  logic [TILE_W-1:0] ld_tile, tile_idx;
  logic              busy, done;
  logic [PERF_W-1:0] perf_cycles;
  logic [2:0]        state_dbg;

  int errors = 0;
  int checks = 0;

  // monitor tallies
  int sc_cnt = 0, sa_cnt = 0, done_cnt = 0, ld_rise = 0, both_cnt = 0, waitld_cnt = 0;
  logic ld_req_prev = 1'b0;
  logic [TILE_W-1:0] acc_tile_q[$];
  logic [TILE_W-1:0] sa_tile_q[$];
  logic              sa_buf_q[$];
  logic [TILE_W-1:0] exp_q[$];

  conv_tile_sched #(.TILE_W(TILE_W), .DRAIN_CYC(DRAIN_CYC), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_ci(cfg_ci), .cfg_co(cfg_co), .cfg_tiles(cfg_tiles),
    .start_conv(start_conv), .start_again(start_again),
    .pe_cfg_ci(pe_cfg_ci), .pe_cfg_co(pe_cfg_co),
    .pe_tile_done(pe_tile_done), .pe_buf_sel(pe_buf_sel),
    .ld_req(ld_req), .ld_tile(ld_tile), .ld_buf(ld_buf), .ld_ack(ld_ack),
    .tile_idx(tile_idx), .busy(busy), .done(done),
    .perf_cycles(perf_cycles), .state_dbg(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (start_conv) sc_cnt++;
      if (start_again) begin
        sa_cnt++;
        sa_tile_q.push_back(tile_idx);
        sa_buf_q.push_back(pe_buf_sel);
      end
      if (done) done_cnt++;
      if (ld_req && !ld_req_prev) ld_rise++;
      if (ld_req && ld_ack) acc_tile_q.push_back(ld_tile);
      if (start_conv && start_again) both_cnt++;
      if (state_dbg == 3'd4) waitld_cnt++;
    end
    ld_req_prev = ld_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input logic [1:0] ci, input logic [1:0] co, input logic [TILE_W-1:0] t);
    cfg_ci = ci; cfg_co = co; cfg_tiles = t; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    ld_ack = 1'b1; tick(); ld_ack = 1'b0;
  endtask

  task automatic pulse_pe_done();
    pe_tile_done = 1'b1; tick(); pe_tile_done = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (done !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_ci = 2'd3; cfg_co = 2'd3; cfg_tiles = '1;
    pe_tile_done = 1'b0; ld_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({start_conv, start_again, busy, done, ld_req, ld_buf, pe_buf_sel} !== 7'd0) begin errors++; $display("FAIL reset_flags: got %b expected 0", {start_conv, start_again, busy, done, ld_req, ld_buf, pe_buf_sel}); end
    checks++; if ({pe_cfg_ci, pe_cfg_co, ld_tile, tile_idx} !== 16'd0) begin errors++; $display("FAIL reset_fields: got %0h expected 0", {pe_cfg_ci, pe_cfg_co, ld_tile, tile_idx}); end
    checks++; if (perf_cycles !== 16'd0) begin errors++; $display("FAIL reset_perf: got %0h expected 0", perf_cycles); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_tile();
    int sc0, sa0, lr0, d0, n;
    sc0 = sc_cnt; sa0 = sa_cnt; lr0 = ld_rise; d0 = done_cnt;
    start_layer(2'd1, 2'd2, 6'd0);
    checks++; if (start_conv !== 1'b1) begin errors++; $display("FAIL s1_start_conv: got %b expected 1", start_conv); end
    tick();
    checks++; if ({ld_req, ld_tile, ld_buf} !== {1'b1, 6'd0, 1'b0}) begin errors++; $display("FAIL s1_load0: got %0h expected 80", {ld_req, ld_tile, ld_buf}); end
    repeat (3) tick();
    pulse_ack();
    checks++; if (start_again !== 1'b1) begin errors++; $display("FAIL s1_start_again: got %b expected 1", start_again); end
    repeat (20) tick();
    checks++; if (ld_req !== 1'b0) begin errors++; $display("FAIL s1_no_prefetch: got %b expected 0", ld_req); end
    pulse_pe_done();
    wait_done(n);
    checks++; if (n !== DRAIN_CYC) begin errors++; $display("FAIL s1_done_latency: got %0d expected %0d", n, DRAIN_CYC); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL s1_busy_at_done: got %b expected 1", busy); end
    tick();
    checks++; if ({busy, state_dbg} !== 4'd0) begin errors++; $display("FAIL s1_idle: got %0h expected 0", {busy, state_dbg}); end
    checks++; if (perf_cycles !== 16'd31) begin errors++; $display("FAIL s1_perf: got %0d expected 31", perf_cycles); end
    checks++; if ({sc_cnt - sc0, sa_cnt - sa0, ld_rise - lr0, done_cnt - d0} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin errors++; $display("FAIL s1_pulse_counts: got sc=%0d sa=%0d ldr=%0d dn=%0d expected 1 each", sc_cnt - sc0, sa_cnt - sa0, ld_rise - lr0, done_cnt - d0); end
    checks++; if ({pe_cfg_ci, pe_cfg_co, pe_buf_sel} !== {2'd1, 2'd2, 1'b0}) begin errors++; $display("FAIL s1_cfg_buf: got %0h expected %0h", {pe_cfg_ci, pe_cfg_co, pe_buf_sel}, {2'd1, 2'd2, 1'b0}); end
  endtask

  task automatic test_multi_tile();
    int acc0, sa_i0, n;
    logic b;
    start_layer(2'd2, 2'd3, 6'd3);
    tick();
    acc0 = acc_tile_q.size(); sa_i0 = sa_tile_q.size();
    pulse_ack();
    for (int t = 0; t < 4; t++) begin
      b = t[0];
      checks++; if ({start_again, tile_idx, pe_buf_sel} !== {1'b1, 6'(t), b}) begin errors++; $display("FAIL s2_launch_%0d: got sa=%b idx=%0d buf=%b expected 1 %0d %b", t, start_again, tile_idx, pe_buf_sel, t, b); end
      tick();
      if (t < 3) begin
        checks++; if ({ld_req, ld_tile, ld_buf} !== {1'b1, 6'(t + 1), ~b}) begin errors++; $display("FAIL s2_prefetch_%0d: got req=%b tile=%0d buf=%b expected 1 %0d %b", t, ld_req, ld_tile, ld_buf, t + 1, ~b); end
        pulse_ack();
        checks++; if (ld_req !== 1'b0) begin errors++; $display("FAIL s2_req_drop_%0d: got %b expected 0", t, ld_req); end
      end else begin
        checks++; if (ld_req !== 1'b0) begin errors++; $display("FAIL s2_last_no_req: got %b expected 0", ld_req); end
        tick();
      end
      pulse_pe_done();
    end
    wait_done(n);
    checks++; if (n !== DRAIN_CYC) begin errors++; $display("FAIL s2_done_latency: got %0d expected %0d", n, DRAIN_CYC); end
    tick();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(6'(i));
    checks++; if (acc_tile_q.size() - acc0 !== 4) begin errors++; $display("FAIL s2_ld_count: got %0d expected 4", acc_tile_q.size() - acc0); end
    for (int i = 0; i < 4 && acc0 + i < acc_tile_q.size(); i++) begin
      checks++; if (acc_tile_q[acc0 + i] !== exp_q[i]) begin errors++; $display("FAIL s2_ld_tile_%0d: got %0d expected %0d", i, acc_tile_q[acc0 + i], exp_q[i]); end
    end
    for (int i = 0; i < 4 && sa_i0 + i < sa_tile_q.size(); i++) begin
      b = i[0];
      checks++; if ({sa_tile_q[sa_i0 + i], sa_buf_q[sa_i0 + i]} !== {exp_q[i], b}) begin errors++; $display("FAIL s2_launch_log_%0d: got %0d/%b expected %0d/%b", i, sa_tile_q[sa_i0 + i], sa_buf_q[sa_i0 + i], exp_q[i], b); end
    end
  endtask

  task automatic test_late_ack();
    int n;
    start_layer(2'd0, 2'd1, 6'd1);
    tick();
    pulse_ack();
    tick();
    checks++; if ({ld_req, ld_tile} !== {1'b1, 6'd1}) begin errors++; $display("FAIL s3_prefetch: got %0h expected 41", {ld_req, ld_tile}); end
    tick();
    pulse_pe_done();
    checks++; if (state_dbg !== 3'd4) begin errors++; $display("FAIL s3_waitld: got %0d expected 4", state_dbg); end
    checks++; if ({ld_req, ld_tile, ld_buf, start_again} !== {1'b1, 6'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL s3_waitld_req: got %0h expected 106", {ld_req, ld_tile, ld_buf, start_again}); end
    repeat (4) tick();
    checks++; if ({state_dbg, start_again} !== {3'd4, 1'b0}) begin errors++; $display("FAIL s3_still_wait: got %0h expected 8", {state_dbg, start_again}); end
    pulse_ack();
    checks++; if ({state_dbg, start_again, tile_idx, pe_buf_sel} !== {3'd3, 1'b1, 6'd1, 1'b1}) begin errors++; $display("FAIL s3_relaunch: got st=%0d sa=%b idx=%0d buf=%b expected 3 1 1 1", state_dbg, start_again, tile_idx, pe_buf_sel); end
    tick();
    checks++; if (ld_req !== 1'b0) begin errors++; $display("FAIL s3_last_no_req: got %b expected 0", ld_req); end
    pulse_pe_done();
    wait_done(n);
    checks++; if (n !== DRAIN_CYC) begin errors++; $display("FAIL s3_done_latency: got %0d expected %0d", n, DRAIN_CYC); end
    tick();
  endtask

  task automatic test_back_to_back();
    int w0, n;
    w0 = waitld_cnt;
    start_layer(2'd3, 2'd0, 6'd1);
    tick();
    pulse_ack();
    tick();
    checks++; if (ld_req !== 1'b1) begin errors++; $display("FAIL s4_prefetch: got %b expected 1", ld_req); end
    ld_ack = 1'b1; pe_tile_done = 1'b1;
    tick();
    ld_ack = 1'b0; pe_tile_done = 1'b0;
    checks++; if ({state_dbg, start_again, tile_idx, pe_buf_sel} !== {3'd3, 1'b1, 6'd1, 1'b1}) begin errors++; $display("FAIL s4_direct_swap: got st=%0d sa=%b idx=%0d buf=%b expected 3 1 1 1", state_dbg, start_again, tile_idx, pe_buf_sel); end
    tick();
    pulse_pe_done();
    wait_done(n);
    checks++; if (n !== DRAIN_CYC) begin errors++; $display("FAIL s4_done_latency: got %0d expected %0d", n, DRAIN_CYC); end
    tick();
    checks++; if (waitld_cnt - w0 !== 0) begin errors++; $display("FAIL s4_no_waitld: got %0d expected 0", waitld_cnt - w0); end
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    start_layer(2'd3, 2'd2, 6'd3);
    tick();
    pulse_ack();
    for (int t = 0; t < 2; t++) begin
      tick();
      pulse_ack();
      pulse_pe_done();
    end
    tick();
    tick();
    checks++; if ({tile_idx, ld_req} !== {6'd2, 1'b1}) begin errors++; $display("FAIL s5_mid_tile2: got idx=%0d req=%b expected 2 1", tile_idx, ld_req); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({busy, ld_req, start_conv, start_again, done, state_dbg} !== 8'd0) begin errors++; $display("FAIL s5_after_abort: got %0h expected 0", {busy, ld_req, start_conv, start_again, done, state_dbg}); end
    checks++; if ({pe_cfg_ci, pe_cfg_co} !== {2'd3, 2'd2}) begin errors++; $display("FAIL s5_cfg_kept: got %0h expected e", {pe_cfg_ci, pe_cfg_co}); end
    checks++; if (perf_cycles !== 16'd11) begin errors++; $display("FAIL s5_perf_abort: got %0d expected 11", perf_cycles); end
    repeat (10) tick();
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL s5_no_done: got %0d expected 0", done_cnt - d0); end
    checks++; if (perf_cycles !== 16'd11) begin errors++; $display("FAIL s5_perf_hold: got %0d expected 11", perf_cycles); end
    start_layer(2'd1, 2'd1, 6'd1);
    checks++; if ({start_conv, tile_idx, pe_cfg_ci} !== {1'b1, 6'd0, 2'd1}) begin errors++; $display("FAIL s5_restart: got sc=%b idx=%0d ci=%0d expected 1 0 1", start_conv, tile_idx, pe_cfg_ci); end
    checks++; if (perf_cycles !== 16'd0) begin errors++; $display("FAIL s5_perf_clear: got %0d expected 0", perf_cycles); end
    tick();
    pulse_ack();
    checks++; if ({start_again, tile_idx, pe_buf_sel} !== {1'b1, 6'd0, 1'b0}) begin errors++; $display("FAIL s5_restart_tile0: got sa=%b idx=%0d buf=%b expected 1 0 0", start_again, tile_idx, pe_buf_sel); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL s5_abort2: got %0d expected 0", state_dbg); end
  endtask

  task automatic test_spurious();
    int n, d0;
    start_layer(2'd2, 2'd1, 6'd0);
    start = 1'b1; cfg_ci = 2'd3; cfg_tiles = 6'd5;
    tick();
    start = 1'b0;
    checks++; if ({state_dbg, start_conv, pe_cfg_ci} !== {3'd2, 1'b0, 2'd2}) begin errors++; $display("FAIL s6_start_busy: got st=%0d sc=%b ci=%0d expected 2 0 2", state_dbg, start_conv, pe_cfg_ci); end
    pulse_pe_done();
    checks++; if ({state_dbg, ld_req, tile_idx} !== {3'd2, 1'b1, 6'd0}) begin errors++; $display("FAIL s6_done_in_load0: got st=%0d req=%b idx=%0d expected 2 1 0", state_dbg, ld_req, tile_idx); end
    pulse_ack();
    tick();
    checks++; if (ld_req !== 1'b0) begin errors++; $display("FAIL s6_single_no_req: got %b expected 0", ld_req); end
    pulse_ack();
    checks++; if ({state_dbg, start_again, tile_idx} !== {3'd3, 1'b0, 6'd0}) begin errors++; $display("FAIL s6_stray_ack: got st=%0d sa=%b idx=%0d expected 3 0 0", state_dbg, start_again, tile_idx); end
    pulse_pe_done();
    wait_done(n);
    checks++; if (n !== DRAIN_CYC) begin errors++; $display("FAIL s6_done_latency: got %0d expected %0d", n, DRAIN_CYC); end
    tick();
    checks++; if (perf_cycles !== 16'd11) begin errors++; $display("FAIL s6_perf: got %0d expected 11", perf_cycles); end
    d0 = done_cnt;
    pulse_ack();
    pulse_pe_done();
    tick();
    checks++; if ({state_dbg, busy, tile_idx} !== 10'd0) begin errors++; $display("FAIL s6_idle_stray: got %0h expected 0", {state_dbg, busy, tile_idx}); end
    checks++; if ({perf_cycles, done_cnt - d0} !== {16'd11, 32'd0}) begin errors++; $display("FAIL s6_idle_hold: got perf=%0d dn=%0d expected 11 0", perf_cycles, done_cnt - d0); end
  endtask

  task automatic test_saturation();
    int n;
    start_layer(2'd0, 2'd0, 6'd0);
    tick();
    pulse_ack();
    repeat (65600) tick();
    checks++; if (perf_cycles !== 16'hFFFF) begin errors++; $display("FAIL s7_sat_run: got %0h expected ffff", perf_cycles); end
    pulse_pe_done();
    wait_done(n);
    checks++; if (n !== DRAIN_CYC) begin errors++; $display("FAIL s7_done_latency: got %0d expected %0d", n, DRAIN_CYC); end
    tick();
    checks++; if ({perf_cycles, busy} !== {16'hFFFF, 1'b0}) begin errors++; $display("FAIL s7_sat_final: got perf=%0h busy=%b expected ffff 0", perf_cycles, busy); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL pulse_overlap: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_late_ack();
    test_back_to_back();
    test_abort();
    test_spurious();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
